cmult_pipe: RTL and testbench



---
 rtl/cmult_pkg.sv | 17 +
 rtl/cmult_round_sat.sv | 49 ++++
 rtl/cmult_pipe.sv | 137 +++++++++++++
 tb/tb_cmult_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmult_pkg.sv
// Shared constants and width relations for the pipelined complex multiplier.
package cmult_pkg;

   localparam int ROUND_TRUNC   = 0;
   localparam int ROUND_HALF_UP = 1;

   // Width of one N x N signed product.
   function automatic int prod_w(input int n);
      return 2 * n;
   endfunction

   // Width of a sum/difference of two products, with no loss of precision.
   function automatic int sum_w(input int n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/cmult_round_sat.sv
// Combinational round/shift of one full-precision component down to N bits; no latency, no handshake.
// Saturates and flags ovf when CMULT_SAT_EN is defined, otherwise keeps the low N bits.
module cmult_round_sat
   import cmult_pkg::*;
#(
   parameter int N     = 16,
   parameter int Q     = 14,
   parameter int ROUND = ROUND_HALF_UP
) (
   input  logic signed [sum_w(N)-1:0] din,
   output logic        [N-1:0]        dout,
   output logic                       ovf
);

   localparam int SW = sum_w(N);
   localparam int EW = SW + 1;
   localparam logic signed [EW-1:0] BIAS =
      (ROUND == ROUND_HALF_UP) ? EW'(1) << (Q - 1) : EW'(0);

   logic signed [EW-1:0] scaled;

   // One guard bit keeps the rounding add exact before the arithmetic shift.
   assign scaled = ($signed({din[SW-1], din}) + BIAS) >>> Q;

`ifdef CMULT_SAT_EN
   logic pos_ovf;
   logic neg_ovf;

   assign pos_ovf = !scaled[EW-1] && (|scaled[EW-2:N-1]);
   assign neg_ovf =  scaled[EW-1] && !(&scaled[EW-2:N-1]);

   always_comb begin
      dout = scaled[N-1:0];
      if (pos_ovf)
         dout = {1'b0, {(N-1){1'b1}}};
      else if (neg_ovf)
         dout = {1'b1, {(N-1){1'b0}}};
   end

   assign ovf = pos_ovf | neg_ovf;
`else
   logic unused_hi;

   assign unused_hi = ^scaled[EW-1:N];
   assign dout      = scaled[N-1:0];
   assign ovf       = 1'b0;
`endif

endmodule

// File: rtl/cmult_pipe.sv
// Pipelined complex multiplier p = a*b or a*conj(b): 3 register stages, one beat per clock.
// Global stall holds every stage while out_valid && !out_ready; CMULT_SAT_EN enables saturation and ovf.
module cmult_pipe
   import cmult_pkg::*;
#(
   parameter int N     = 16,
   parameter int Q     = 14,
   parameter int ROUND = ROUND_HALF_UP
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         conj_b,
   input  logic [N-1:0] a_re,
   input  logic [N-1:0] a_im,
   input  logic [N-1:0] b_re,
   input  logic [N-1:0] b_im,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] p_re,
   output logic [N-1:0] p_im,
   output logic         ovf
);

   localparam int PW = prod_w(N);
   localparam int SW = sum_w(N);

   logic en;

   logic                v1;
   logic                cj1;
   logic signed [N-1:0] ar1, ai1, br1, bi1;

   logic                 v2;
   logic                 cj2;
   logic signed [PW-1:0] pr_rr, pr_ii, pr_ri, pr_ir;

   logic signed [SW-1:0] re_sum, im_sum;
   logic        [N-1:0]  re_n, im_n;
   logic                 ovf_re, ovf_im;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         cj1 <= 1'b0;
         ar1 <= '0;
         ai1 <= '0;
         br1 <= '0;
         bi1 <= '0;
      end else if (en) begin
         v1 <= in_valid;
         if (in_valid) begin
            cj1 <= conj_b;
            ar1 <= a_re;
            ai1 <= a_im;
            br1 <= b_re;
            bi1 <= b_im;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2    <= 1'b0;
         cj2   <= 1'b0;
         pr_rr <= '0;
         pr_ii <= '0;
         pr_ri <= '0;
         pr_ir <= '0;
      end else if (en) begin
         v2 <= v1;
         if (v1) begin
            cj2   <= cj1;
            pr_rr <= PW'(ar1) * PW'(br1);
            pr_ii <= PW'(ai1) * PW'(bi1);
            pr_ri <= PW'(ar1) * PW'(bi1);
            pr_ir <= PW'(ai1) * PW'(br1);
         end
      end
   end

   // conj(B) flips the sign of every b_im term.
   always_comb begin
      if (cj2) begin
         re_sum = SW'(pr_rr) + SW'(pr_ii);
         im_sum = SW'(pr_ir) - SW'(pr_ri);
      end else begin
         re_sum = SW'(pr_rr) - SW'(pr_ii);
         im_sum = SW'(pr_ri) + SW'(pr_ir);
      end
   end

   cmult_round_sat #(.N(N), .Q(Q), .ROUND(ROUND)) u_rs_re (
      .din  (re_sum),
      .dout (re_n),
      .ovf  (ovf_re)
   );

   cmult_round_sat #(.N(N), .Q(Q), .ROUND(ROUND)) u_rs_im (
      .din  (im_sum),
      .dout (im_n),
      .ovf  (ovf_im)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         p_re      <= '0;
         p_im      <= '0;
      end else if (en) begin
         out_valid <= v2;
         if (v2) begin
            p_re <= re_n;
            p_im <= im_n;
         end
      end
   end

`ifdef CMULT_SAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else if (en && v2)
         ovf <= ovf_re | ovf_im;
   end
`else
   logic unused_ovf;

   assign unused_ovf = ovf_re | ovf_im;
   assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_cmult_pipe.sv
// Directed and model-checked bench for cmult_pipe (N=16, Q=14), ROUND=1 and ROUND=0 instances side by side.
module tb_cmult_pipe;

   localparam int N = 16;
   localparam int Q = 14;

   typedef struct {
      longint re;
      longint im;
      bit     ov;
   } res_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, conj_b, out_ready;
   logic [N-1:0] a_re, a_im, b_re, b_im;
   logic         in_ready, out_valid, ovf;
   logic [N-1:0] p_re, p_im;
   logic         t_in_ready, t_out_valid, t_ovf;
   logic [N-1:0] t_p_re, t_p_im;

   int   n_chk = 0;
   int   n_err = 0;
   int   n_out = 0;
   bit   prev_stall = 1'b0;
   res_t exp_q[$];
   res_t expt_q[$];

   always #5 clk = ~clk;

   cmult_pipe #(.N(N), .Q(Q), .ROUND(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .conj_b(conj_b),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(out_valid), .out_ready(out_ready), .p_re(p_re), .p_im(p_im), .ovf(ovf)
   );

   cmult_pipe #(.N(N), .Q(Q), .ROUND(0)) dut_t (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready), .conj_b(conj_b),
      .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
      .out_valid(t_out_valid), .out_ready(out_ready), .p_re(t_p_re), .p_im(t_p_im), .ovf(t_ovf)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint scale(input longint v, input int rnd, output bit ov);
      longint s;
      s  = (v + (rnd != 0 ? 64'sd8192 : 64'sd0)) >>> Q;
      ov = 1'b0;
`ifdef CMULT_SAT_EN
      if (s > 32767) begin
         s  = 32767;
         ov = 1'b1;
      end else if (s < -32768) begin
         s  = -32768;
         ov = 1'b1;
      end
`else
      s = ((s % 65536) + 65536) % 65536;
      if (s >= 32768) s = s - 65536;
`endif
      return s;
   endfunction

   function automatic res_t model(input longint ar, input longint ai, input longint br,
                                  input longint bi, input bit cj, input int rnd);
      res_t   r;
      longint re, im;
      bit     o1, o2;
      if (!cj) begin
         re = ar * br - ai * bi;
         im = ar * bi + ai * br;
      end else begin
         re = ar * br + ai * bi;
         im = ai * br - ar * bi;
      end
      r.re = scale(re, rnd, o1);
      r.im = scale(im, rnd, o2);
      r.ov = o1 | o2;
      return r;
   endfunction

   task automatic drive(input longint ar, input longint ai, input longint br,
                        input longint bi, input bit cj);
      a_re   = N'(ar);
      a_im   = N'(ai);
      b_re   = N'(br);
      b_im   = N'(bi);
      conj_b = cj;
   endtask

   // One clock: called at posedge+1 with inputs set, returns at the next posedge+1.
   task automatic step(output bit acc);
      res_t e, et;
      #1;
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (prev_stall) check("stall_valid", out_valid, 1);
      if (out_valid) begin
         check("out_has_exp", exp_q.size() != 0, 1);
         if (exp_q.size() != 0 && expt_q.size() != 0) begin
            e  = exp_q[0];
            et = expt_q[0];
            check("p_re", $signed(p_re), e.re);
            check("p_im", $signed(p_im), e.im);
            check("ovf", ovf, e.ov);
            check("t_p_re", $signed(t_p_re), et.re);
            check("t_p_im", $signed(t_p_im), et.im);
            if (out_ready) begin
               void'(exp_q.pop_front());
               void'(expt_q.pop_front());
               n_out++;
            end
         end
      end
      acc = in_valid && in_ready;
      if (acc) begin
         exp_q.push_back(model($signed(a_re), $signed(a_im), $signed(b_re), $signed(b_im), conj_b, 1));
         expt_q.push_back(model($signed(a_re), $signed(a_im), $signed(b_re), $signed(b_im), conj_b, 0));
      end
      prev_stall = out_valid && !out_ready;
      @(posedge clk);
      #1;
   endtask

   // Single beat into an empty pipe, checked against hand-computed values.
   task automatic vec(input string tag, input longint ar, input longint ai, input longint br,
                      input longint bi, input bit cj, input longint er, input longint ei,
                      input longint eo, input longint tr, input longint ti);
      bit acc;
      int lat;
      drive(ar, ai, br, bi, cj);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step(acc);
      check({tag, "_acc"}, acc, 1);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         step(acc);
         lat++;
      end
      check({tag, "_lat"}, lat, 3);
      check({tag, "_re"}, $signed(p_re), er);
      check({tag, "_im"}, $signed(p_im), ei);
      check({tag, "_ovf"}, ovf, eo);
      check({tag, "_t_re"}, $signed(t_p_re), tr);
      check({tag, "_t_im"}, $signed(t_p_im), ti);
      step(acc);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bit          acc;
      int          idx, cyc, base;
      logic [15:0] pat;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; conj_b = 1'b0;
      a_re = '0; a_im = '0; b_re = '0; b_im = '0;
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_p_re", p_re, 0);
      check("rst_p_im", p_im, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      vec("basic", 16384, 0, 8192, -8192, 1'b0, 8192, -8192, 0, 8192, -8192);
      vec("conj", 16384, 0, 8192, -8192, 1'b1, 8192, 8192, 0, 8192, 8192);
      vec("rnd_pos", 1, 0, 8192, 0, 1'b0, 1, 0, 0, 0, 0);
      vec("rnd_neg", -1, 0, 8192, 0, 1'b0, 0, 0, 0, -1, 0);
`ifdef CMULT_SAT_EN
      vec("ovfl", 32767, 32767, 32767, -32767, 1'b0, 32767, 0, 1, 32767, 0);
`else
      vec("ovfl", 32767, 32767, 32767, -32767, 1'b0, -8, 0, 0, -8, 0);
`endif

      // Backpressure: 8 beats offered back-to-back, out_ready follows a fixed irregular pattern.
      pat = 16'b1011_0010_1101_0110;
      idx = 0;
      cyc = 0;
      while ((idx < 8 || exp_q.size() != 0) && cyc < 200) begin
         out_ready = pat[cyc % 16];
         if (idx < 8) begin
            drive(1000 * idx - 3500, 20000 - 3000 * idx, -12000 + 2500 * idx, 7000 - 900 * idx, idx[0]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step(acc);
         if (acc) idx++;
         cyc++;
      end
      check("bp_accepted", idx, 8);
      check("bp_drained", exp_q.size(), 0);

      // Throughput: 100 random beats with out_ready held high.
      in_valid  = 1'b0;
      out_ready = 1'b1;
      base = n_out;
      idx  = 0;
      for (cyc = 0; cyc < 150; cyc++) begin
         if (idx < 100) begin
            drive($signed(16'($urandom)), $signed(16'($urandom)), $signed(16'($urandom)),
                  $signed(16'($urandom)), 1'($urandom));
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step(acc);
         if (acc) idx++;
         if (n_out - base == 100) break;
      end
      check("thru_results", n_out - base, 100);
      check("thru_cycles", cyc, 102);

      // Reset with three beats in flight.
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(4000 + i, -2000, 3000, 1000 * i, 1'b0);
         in_valid = 1'b1;
         step(acc);
      end
      in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_p_re", p_re, 0);
      check("mid_rst_p_im", p_im, 0);
      check("mid_rst_t_valid", t_out_valid, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      exp_q.delete();
      expt_q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         step(acc);
         check("post_rst_idle", out_valid, 0);
      end
      vec("post_rst", 16384, 0, 8192, -8192, 1'b0, 8192, -8192, 0, 8192, -8192);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
